// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE sequencing controller:
// state encoding, address-source selects and the output bundle.
package pe_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE, CLR, FILT, TMP, WIN, MINIT,
      CALC, PUSH, CHK, WRO, WRC, FIN
   } state_t;

   localparam logic [1:0] SEL_TEMP = 2'b00;
   localparam logic [1:0] SEL_FILT = 2'b01;
   localparam logic [1:0] SEL_OFM  = 2'b10;

   typedef struct packed {
      logic       ldAdr;
      logic       rstX;
      logic       rstWR;
      logic       ldWR;
      logic       rstCalc;
      logic       enCalc;
      logic       WEview;
      logic       REview;
      logic       WEFilter;
      logic       REFilter;
      logic       WETemp;
      logic       RETemp;
      logic       rstTemp;
      logic       rstFilter;
      logic       lastWR;
      logic [1:0] sel;
      logic       WEofm;
      logic       busy;
      logic       done;
   } ctrl_t;

   // Decoded from the state being entered so strobes line up with it.
   function automatic ctrl_t decode(state_t s, logic last);
      ctrl_t c;
      c = '0;
      c.sel = SEL_TEMP;
      c.busy = (s != IDLE);
      case (s)
         CLR: begin
            c.rstX = 1'b1;
            c.rstWR = 1'b1;
            c.rstCalc = 1'b1;
            c.rstTemp = 1'b1;
            c.rstFilter = 1'b1;
         end
         FILT: begin
            c.sel = SEL_FILT;
            c.ldAdr = 1'b1;
            c.WEFilter = 1'b1;
         end
         TMP: begin
            c.sel = SEL_TEMP;
            c.ldAdr = 1'b1;
            c.WETemp = 1'b1;
         end
         WIN: begin
            c.RETemp = 1'b1;
            c.WEview = 1'b1;
         end
         MINIT: c.rstCalc = 1'b1;
         CALC: begin
            c.enCalc = 1'b1;
            c.REview = 1'b1;
            c.REFilter = 1'b1;
         end
         PUSH: begin
            c.ldWR = 1'b1;
            c.lastWR = last;
         end
         WRO: begin
            c.sel = SEL_OFM;
            c.ldAdr = 1'b1;
            c.WEofm = 1'b1;
         end
         WRC: c.rstWR = 1'b1;
         FIN: c.done = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pe_controller_if.sv
// Control/status bundle between the controller and one PE.
// master = controller side, slave = PE side.
interface pe_controller_if;

   logic       doneAdr;
   logic       fullWR;
   logic       macDone;
   logic       fullFilter;
   logic       fullTemp;
   logic       emptyTemp;
   logic       ldAdr;
   logic       rstX;
   logic       rstWR;
   logic       ldWR;
   logic       rstCalc;
   logic       enCalc;
   logic       WEview;
   logic       REview;
   logic       WEFilter;
   logic       REFilter;
   logic       WETemp;
   logic       RETemp;
   logic       rstTemp;
   logic       rstFilter;
   logic       lastWR;
   logic [1:0] sel;
   logic       WEofm;

   modport master (
      input  doneAdr, fullWR, macDone,
      input  fullFilter, fullTemp, emptyTemp,
      output ldAdr, rstX, rstWR, ldWR,
      output rstCalc, enCalc, WEview, REview,
      output WEFilter, REFilter, WETemp, RETemp,
      output rstTemp, rstFilter, lastWR, sel, WEofm
   );

   modport slave (
      output doneAdr, fullWR, macDone,
      output fullFilter, fullTemp, emptyTemp,
      input  ldAdr, rstX, rstWR, ldWR,
      input  rstCalc, enCalc, WEview, REview,
      input  WEFilter, REFilter, WETemp, RETemp,
      input  rstTemp, rstFilter, lastWR, sel, WEofm
   );

endinterface

// File: rtl/pe_win_counter.sv
// Window counter for one run; flags the last window
// and the point where every window has been pushed.
module pe_win_counter #(
   parameter int NUM_WINDOWS = 16,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last,
   output logic all
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
   end

   assign last = (cnt == CNT_W'(NUM_WINDOWS - 1));
   assign all  = (cnt == CNT_W'(NUM_WINDOWS));

endmodule

// File: rtl/pe_controller.sv
// Sequences one PE: clear, fill filter/temp, window,
// MAC, pack into the write-result register, write OFM.
module pe_controller
   import pe_ctrl_pkg::*;
#(
   parameter int NUM_WINDOWS = 16,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   pe_controller_if.master pe,
   output logic busy,
   output logic done
);

   state_t state, nxt;
   ctrl_t ctrl;
   logic winLast, winAll;

   pe_win_counter #(
      .NUM_WINDOWS(NUM_WINDOWS),
      .CNT_W(CNT_W)
   ) winCounter (
      .clk(clk),
      .rst(rst),
      .clr(state == CLR),
      .inc(state == PUSH),
      .last(winLast),
      .all(winAll)
   );

   // winAll already reflects the increment made in PUSH when CHK runs.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  if (start) nxt = CLR;
         CLR:   nxt = FILT;
         FILT:  if (pe.fullFilter) nxt = TMP;
         TMP:   if (pe.fullTemp) nxt = WIN;
         WIN:   nxt = MINIT;
         MINIT: nxt = CALC;
         CALC:  if (pe.macDone) nxt = PUSH;
         PUSH:  nxt = CHK;
         CHK: begin
            if (pe.fullWR || winAll) nxt = WRO;
            else nxt = pe.emptyTemp ? TMP : WIN;
         end
         WRO:   nxt = WRC;
         WRC: begin
            if (winAll) nxt = FIN;
            else nxt = pe.emptyTemp ? TMP : WIN;
         end
         FIN:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ctrl <= '0;
      end else begin
         state <= nxt;
         ctrl <= decode(nxt, winLast);
      end
   end

   assign pe.ldAdr     = ctrl.ldAdr;
   assign pe.rstX      = ctrl.rstX;
   assign pe.rstWR     = ctrl.rstWR;
   assign pe.ldWR      = ctrl.ldWR;
   assign pe.rstCalc   = ctrl.rstCalc;
   assign pe.enCalc    = ctrl.enCalc;
   assign pe.WEview    = ctrl.WEview;
   assign pe.REview    = ctrl.REview;
   assign pe.WEFilter  = ctrl.WEFilter;
   assign pe.REFilter  = ctrl.REFilter;
   assign pe.WETemp    = ctrl.WETemp;
   assign pe.RETemp    = ctrl.RETemp;
   assign pe.rstTemp   = ctrl.rstTemp;
   assign pe.rstFilter = ctrl.rstFilter;
   assign pe.lastWR    = ctrl.lastWR;
   assign pe.sel       = ctrl.sel;
   assign pe.WEofm     = ctrl.WEofm;
   assign busy         = ctrl.busy;
   assign done         = ctrl.done;

endmodule

// File: tb/tb_pe_controller.sv
// Bench for pe_controller: two instances (4 and 8 windows),
// each driven by a small behavioural PE model.
module tb_pe_controller;
   import pe_ctrl_pkg::*;

   logic clk = 1'b0;
   logic [1:0] rstV = 2'b11;
   logic [1:0] startV = 2'b00;
   logic doneAdrV = 1'b0;
   int checks = 0;
   int failures = 0;
   int cfgWrEvery [2] = '{99, 99};
   int cfgEmptyAt [2] = '{0, 0};
   bit expLast [$];

   wire [19:0] outW [2];
   wire [31:0] ldW [2];
   wire [31:0] ofmW [2];
   wire [31:0] badSelW [2];
   wire [31:0] rstOfmW [2];
   wire [31:0] doneW [2];
   wire [31:0] refillW [2];
   wire [63:0] lastW [2];

   localparam int B_RSTX = 18;
   localparam int B_ENCALC = 14;
   localparam int B_WETEMP = 9;
   localparam int B_BUSY = 1;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int NW = (g == 0) ? 4 : 8;
      pe_controller_if pIf ();
      logic busy, done;

      pe_controller #(.NUM_WINDOWS(NW), .CNT_W(8)) dut (
         .clk(clk),
         .rst(rstV[g]),
         .start(startV[g]),
         .pe(pIf),
         .busy(busy),
         .done(done)
      );

      int filtCnt = 0, tempCnt = 0, macCnt = 0;
      int wrCnt = 0, pushCnt = 0;
      bit lastFlag = 1'b0, emptyT = 1'b0, prevOfm = 1'b0;
      logic [31:0] ldN = 0, ofmN = 0, badSel = 0;
      logic [31:0] rstOfm = 0, doneN = 0, refillN = 0;
      logic [63:0] lastObs = '0;

      assign pIf.doneAdr = doneAdrV;
      assign pIf.fullFilter = (filtCnt >= 3);
      assign pIf.fullTemp = (tempCnt >= 4);
      assign pIf.macDone = (macCnt >= 5);
      assign pIf.fullWR = (wrCnt >= cfgWrEvery[g]) || lastFlag;
      assign pIf.emptyTemp = emptyT;

      always @(posedge clk) begin
         if (pIf.rstFilter) filtCnt <= 0;
         else if (pIf.WEFilter) filtCnt <= filtCnt + 1;
         if (pIf.rstTemp) begin
            tempCnt <= 0;
            emptyT <= 1'b0;
         end else if (pIf.ldWR && pushCnt + 1 == cfgEmptyAt[g]) begin
            tempCnt <= 0;
            emptyT <= 1'b1;
         end else if (pIf.WETemp) begin
            tempCnt <= tempCnt + 1;
            emptyT <= 1'b0;
         end
         if (pIf.rstCalc) macCnt <= 0;
         else if (pIf.enCalc) macCnt <= macCnt + 1;
         if (pIf.rstWR) begin
            wrCnt <= 0;
            lastFlag <= 1'b0;
         end else if (pIf.ldWR) begin
            wrCnt <= wrCnt + 1;
            lastFlag <= pIf.lastWR;
         end
         if (pIf.rstX) pushCnt <= 0;
         else if (pIf.ldWR) pushCnt <= pushCnt + 1;
      end

      always @(negedge clk) begin
         if (pIf.ldWR) begin
            if (ldN < 64) lastObs[ldN[5:0]] <= pIf.lastWR;
            ldN <= ldN + 1;
         end
         if (pIf.WEofm) begin
            ofmN <= ofmN + 1;
            if (pIf.sel !== 2'b10) badSel <= badSel + 1;
         end
         if (prevOfm && pIf.rstWR) rstOfm <= rstOfm + 1;
         prevOfm <= pIf.WEofm;
         if (done) doneN <= doneN + 1;
         if (pIf.WETemp && pIf.sel === 2'b00 && pushCnt == 2)
            refillN <= refillN + 1;
      end

      assign outW[g] = {pIf.ldAdr, pIf.rstX, pIf.rstWR, pIf.ldWR,
                        pIf.rstCalc, pIf.enCalc, pIf.WEview,
                        pIf.REview, pIf.WEFilter, pIf.REFilter,
                        pIf.WETemp, pIf.RETemp, pIf.rstTemp,
                        pIf.rstFilter, pIf.lastWR, pIf.sel,
                        pIf.WEofm, busy, done};
      assign ldW[g] = ldN;
      assign ofmW[g] = ofmN;
      assign badSelW[g] = badSel;
      assign rstOfmW[g] = rstOfm;
      assign doneW[g] = doneN;
      assign refillW[g] = refillN;
      assign lastW[g] = lastObs;
   end

   task automatic pulseStart(input int g);
      @(negedge clk);
      startV[g] = 1'b1;
      @(negedge clk);
      startV[g] = 1'b0;
   endtask

   task automatic waitDone(input int g, input logic [31:0] base,
                           output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (doneW[g] != base) ok = 1'b1;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      int bad [2];
      rstV = 2'b11;
      startV = 2'b00;
      repeat (2) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (outW[g] !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs inst=%0d got=%b want=0", g, outW[g]);
         end
      end
      rstV = 2'b00;
      bad = '{0, 0};
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++)
            if (outW[g] !== 20'd0) bad[g]++;
      end
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (bad[g] !== 0) begin
            failures++;
            $display("FAIL idle_hold inst=%0d got=%0d want=0 active cycles", g, bad[g]);
         end
      end
      checks++;
      if (u[0].dut.state !== IDLE) begin
         failures++;
         $display("FAIL idle_state got=%0d want=%0d", u[0].dut.state, IDLE);
      end
   endtask

   task automatic test_basic();
      logic [31:0] ld0, ofm0, bad0, rs0, dn0;
      bit ok, e;
      int k;
      cfgWrEvery[0] = 4;
      cfgEmptyAt[0] = 0;
      ld0 = ldW[0]; ofm0 = ofmW[0]; bad0 = badSelW[0];
      rs0 = rstOfmW[0]; dn0 = doneW[0];
      for (int i = 0; i < 4; i++) expLast.push_back(i == 3);
      pulseStart(0);
      waitDone(0, dn0, ok);
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL basic_timeout got=%0b want=1", ok);
      end
      checks++;
      if (ldW[0] - ld0 !== 32'd4) begin
         failures++;
         $display("FAIL basic_ldWR got=%0d want=4", ldW[0] - ld0);
      end
      k = 0;
      while (expLast.size() > 0) begin
         e = expLast.pop_front();
         checks++;
         if (lastW[0][ld0 + k] !== e) begin
            failures++;
            $display("FAIL basic_lastWR push=%0d got=%b want=%b", k, lastW[0][ld0 + k], e);
         end
         k++;
      end
      checks++;
      if (ofmW[0] - ofm0 !== 32'd1 || badSelW[0] !== bad0) begin
         failures++;
         $display("FAIL basic_WEofm got=%0d badsel=%0d want=1/0", ofmW[0] - ofm0, badSelW[0] - bad0);
      end
      checks++;
      if (rstOfmW[0] - rs0 !== 32'd1) begin
         failures++;
         $display("FAIL basic_rstWR got=%0d want=1", rstOfmW[0] - rs0);
      end
      checks++;
      if (doneW[0] - dn0 !== 32'd1 || outW[0][B_BUSY] !== 1'b0) begin
         failures++;
         $display("FAIL basic_done got=%0d busy=%b want=1/0", doneW[0] - dn0, outW[0][B_BUSY]);
      end
   endtask

   task automatic test_refill();
      logic [31:0] ld0, ofm0, rf0, dn0;
      bit ok, e;
      int k;
      cfgWrEvery[1] = 8;
      cfgEmptyAt[1] = 2;
      ld0 = ldW[1]; ofm0 = ofmW[1]; rf0 = refillW[1]; dn0 = doneW[1];
      for (int i = 0; i < 8; i++) expLast.push_back(i == 7);
      pulseStart(1);
      waitDone(1, dn0, ok);
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL refill_timeout got=%0b want=1", ok);
      end
      checks++;
      if ((refillW[1] - rf0 > 0) !== 1'b1) begin
         failures++;
         $display("FAIL refill_tmp got=%0d want>0 WETemp cycles", refillW[1] - rf0);
      end
      checks++;
      if (ldW[1] - ld0 !== 32'd8) begin
         failures++;
         $display("FAIL refill_ldWR got=%0d want=8", ldW[1] - ld0);
      end
      k = 0;
      while (expLast.size() > 0) begin
         e = expLast.pop_front();
         checks++;
         if (lastW[1][ld0 + k] !== e) begin
            failures++;
            $display("FAIL refill_lastWR push=%0d got=%b want=%b", k, lastW[1][ld0 + k], e);
         end
         k++;
      end
      checks++;
      if (ofmW[1] - ofm0 !== 32'd1 || doneW[1] - dn0 !== 32'd1) begin
         failures++;
         $display("FAIL refill_end got ofm=%0d done=%0d want=1/1", ofmW[1] - ofm0, doneW[1] - dn0);
      end
      cfgEmptyAt[1] = 0;
   endtask

   task automatic test_multi_write();
      logic [31:0] ld0, ofm0, bad0, rs0, dn0;
      bit ok, e;
      int k;
      cfgWrEvery[1] = 4;
      cfgEmptyAt[1] = 0;
      ld0 = ldW[1]; ofm0 = ofmW[1]; bad0 = badSelW[1];
      rs0 = rstOfmW[1]; dn0 = doneW[1];
      for (int i = 0; i < 8; i++) expLast.push_back(i == 7);
      pulseStart(1);
      waitDone(1, dn0, ok);
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL multi_timeout got=%0b want=1", ok);
      end
      checks++;
      if (ofmW[1] - ofm0 !== 32'd2 || badSelW[1] !== bad0) begin
         failures++;
         $display("FAIL multi_WEofm got=%0d badsel=%0d want=2/0", ofmW[1] - ofm0, badSelW[1] - bad0);
      end
      checks++;
      if (rstOfmW[1] - rs0 !== 32'd2) begin
         failures++;
         $display("FAIL multi_rstWR got=%0d want=2", rstOfmW[1] - rs0);
      end
      checks++;
      if (ldW[1] - ld0 !== 32'd8) begin
         failures++;
         $display("FAIL multi_ldWR got=%0d want=8", ldW[1] - ld0);
      end
      k = 0;
      while (expLast.size() > 0) begin
         e = expLast.pop_front();
         checks++;
         if (lastW[1][ld0 + k] !== e) begin
            failures++;
            $display("FAIL multi_lastWR push=%0d got=%b want=%b", k, lastW[1][ld0 + k], e);
         end
         k++;
      end
      checks++;
      if (doneW[1] - dn0 !== 32'd1) begin
         failures++;
         $display("FAIL multi_done got=%0d want=1", doneW[1] - dn0);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] ld0, dn0;
      bit ok, e;
      int k;
      cfgWrEvery[1] = 8;
      cfgEmptyAt[1] = 0;
      dn0 = doneW[1];
      pulseStart(1);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (outW[1][B_ENCALC] === 1'b1) ok = 1'b1;
      end
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL midrst_calc_timeout got=%0b want=1", ok);
      end
      rstV[1] = 1'b1;
      @(negedge clk);
      checks++;
      if (outW[1] !== 20'd0) begin
         failures++;
         $display("FAIL midrst_outputs got=%b want=0", outW[1]);
      end
      rstV[1] = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (doneW[1] !== dn0 || outW[1][B_BUSY] !== 1'b0) begin
         failures++;
         $display("FAIL midrst_nodone got=%0d busy=%b want=0/0", doneW[1] - dn0, outW[1][B_BUSY]);
      end
      ld0 = ldW[1];
      for (int i = 0; i < 8; i++) expLast.push_back(i == 7);
      pulseStart(1);
      checks++;
      if (outW[1][B_RSTX] !== 1'b1) begin
         failures++;
         $display("FAIL midrst_restart_clr got=%b want=1", outW[1][B_RSTX]);
      end
      waitDone(1, dn0, ok);
      checks++;
      if (ok !== 1'b1 || doneW[1] - dn0 !== 32'd1) begin
         failures++;
         $display("FAIL midrst_rerun_done got=%0d want=1", doneW[1] - dn0);
      end
      k = 0;
      while (expLast.size() > 0) begin
         e = expLast.pop_front();
         checks++;
         if (lastW[1][ld0 + k] !== e) begin
            failures++;
            $display("FAIL midrst_lastWR push=%0d got=%b want=%b", k, lastW[1][ld0 + k], e);
         end
         k++;
      end
   endtask

   task automatic test_start_busy();
      logic [31:0] ld0, dn0;
      bit ok, e;
      int k;
      cfgWrEvery[0] = 4;
      cfgEmptyAt[0] = 0;
      doneAdrV = 1'b1;
      ld0 = ldW[0]; dn0 = doneW[0];
      for (int i = 0; i < 4; i++) expLast.push_back(i == 3);
      pulseStart(0);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (outW[0][B_WETEMP] === 1'b1) ok = 1'b1;
      end
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL busy_tmp_timeout got=%0b want=1", ok);
      end
      startV[0] = 1'b1;
      @(negedge clk);
      startV[0] = 1'b0;
      waitDone(0, dn0, ok);
      repeat (20) @(negedge clk);
      checks++;
      if (ok !== 1'b1 || doneW[0] - dn0 !== 32'd1) begin
         failures++;
         $display("FAIL busy_single_done got=%0d want=1", doneW[0] - dn0);
      end
      checks++;
      if (outW[0][B_BUSY] !== 1'b0 || ldW[0] - ld0 !== 32'd4) begin
         failures++;
         $display("FAIL busy_no_rerun got busy=%b ldWR=%0d want=0/4", outW[0][B_BUSY], ldW[0] - ld0);
      end
      k = 0;
      while (expLast.size() > 0) begin
         e = expLast.pop_front();
         checks++;
         if (lastW[0][ld0 + k] !== e) begin
            failures++;
            $display("FAIL busy_lastWR push=%0d got=%b want=%b", k, lastW[0][ld0 + k], e);
         end
         k++;
      end
      doneAdrV = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_refill();
      test_multi_write();
      test_mid_reset();
      test_start_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
